// File: rtl/y_mem_pkg.sv
// rtl/y_mem_pkg.sv - shared funct3, state and byte-enable encodings for the load/store unit
package y_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // True when exactly one direction is set, funct3 is legal for it and the address is aligned.
    function automatic logic access_ok(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
        logic legal_f3;
        logic aligned;
        if (rd)
            legal_f3 = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
        else
            legal_f3 = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        case (f3[1:0])
            2'b01:   aligned = !lo[0];
            2'b10:   aligned = (lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return (rd ^ wr) && legal_f3 && aligned;
    endfunction

endpackage

// File: rtl/y_lsu_if.sv
// rtl/y_lsu_if.sv - word-addressed data memory bus with req/ack handshake
interface y_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/y_lsu_lane.sv
// rtl/y_lsu_lane.sv - store byte-lane steering and load lane extraction/extension
module y_lsu_lane
    import y_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Store side: size picks the enable pattern, data is replicated so every lane carries it.
    always_comb begin
        be    = BE_NONE;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = BE_BYTE << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = BE_WORD;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend by funct3.
    always_comb begin
        byte_v = load_word[{addr_lo, 3'b000} +: 8];
        half_v = load_word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            F3_LH:   load_data = {{16{half_v[15]}}, half_v};
            F3_LBU:  load_data = {24'h0, byte_v};
            F3_LHU:  load_data = {16'h0, half_v};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/y_lsu.sv
// rtl/y_lsu.sv - multi-cycle load/store unit between execute and write-back
module y_lsu
    import y_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] exeOut,
    input  logic [31:0] rd2,
    output logic [31:0] memOut,
    output logic        busy,
    output logic        done,
    output logic        fault,
    y_lsu_if.master     mem
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;

    logic [2:0]  lane_f3;
    logic [1:0]  lane_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    // In IDLE the lane steers the incoming request; afterwards it decodes the latched one.
    assign lane_f3 = (state_q == ST_IDLE) ? funct3 : f3_q;
    assign lane_lo = (state_q == ST_IDLE) ? exeOut[1:0] : addr_q[1:0];

    y_lsu_lane u_lane (
        .funct3     (lane_f3),
        .addr_lo    (lane_lo),
        .store_data (rd2),
        .load_word  (mem.mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // Next-state: accept/reject in IDLE, wait for ack or timeout in REQ, one-cycle DONE/FAULT.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (access_ok(MemRead, MemWrite, funct3, exeOut[1:0])) begin
                        state_d = ST_REQ;
                        addr_d  = exeOut;
                        f3_d    = funct3;
                        we_d    = MemWrite;
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins over a timeout in the same cycle.
                if (mem.mem_ack) begin
                    if (!we_q)
                        out_d = lane_load;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO)
                        state_d = ST_FAULT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            be_q    <= BE_NONE;
            wdata_q <= 32'h0;
            cnt_q   <= 8'd0;
            out_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = mem.mem_req & we_q;
    assign mem.mem_be    = mem.mem_req ? be_q : BE_NONE;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = wdata_q;

    assign memOut = out_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE) || (state_q == ST_FAULT);
    assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_y_lsu.sv
// tb/tb_y_lsu.sv - self-checking bench for y_lsu: vector table, random ops vs reference model, reset corner
module tb_y_lsu;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] exeOut;
    logic [31:0] rd2;
    logic [31:0] memOut;
    logic        busy;
    logic        done;
    logic        fault;

    y_lsu_if bus ();

    y_lsu #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .funct3   (funct3),
        .exeOut   (exeOut),
        .rd2      (rd2),
        .memOut   (memOut),
        .busy     (busy),
        .done     (done),
        .fault    (fault),
        .mem      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] model_out = 32'h0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rd2;
        logic [31:0] rdata;
        int          dly;
        logic        efault;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eout;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access from start to the idle cycle after done; efault covers illegal requests only,
    // a timeout is implied by dly >= TMO.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] d2, input logic [31:0] rdata,
                          input int dly, input logic junk, input logic efault,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eout);
        logic completed;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; exeOut = addr; rd2 = d2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (efault) begin
            chk("illegal_done", done, 1'b1);
            chk("illegal_fault", fault, 1'b1);
            chk("illegal_req", bus.mem_req, 1'b0);
        end else begin
            for (int i = 0; i < TMO; i++) begin
                chk("req_high", bus.mem_req, 1'b1);
                chk("req_busy", busy, 1'b1);
                chk("req_done", done, 1'b0);
                chk("req_we", bus.mem_we, wr);
                chk("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
                if (wr) begin
                    chk("req_be", bus.mem_be, ebe);
                    chk("req_wdata", bus.mem_wdata, ewd);
                end
                if (i == dly) begin
                    bus.mem_rdata = rdata; bus.mem_ack = 1'b1;
                end else begin
                    bus.mem_rdata = $urandom; bus.mem_ack = 1'b0;
                end
                if (junk) begin
                    start = 1'($urandom_range(0, 1));
                    MemRead = 1'($urandom_range(0, 1));
                    MemWrite = 1'($urandom_range(0, 1));
                    funct3 = 3'($urandom_range(0, 7));
                    exeOut = $urandom; rd2 = $urandom;
                end
                @(posedge clk); #1;
                bus.mem_ack = 1'b0; start = 1'b0;
                if (i == dly) break;
            end
            completed = (dly < TMO);
            chk("end_done", done, 1'b1);
            chk("end_fault", fault, !completed);
            chk("end_req", bus.mem_req, 1'b0);
            chk("end_be", bus.mem_be, 4'b0000);
            chk("end_addr_hold", bus.mem_addr, {addr[31:2], 2'b00});
        end
        chk("end_memout", memOut, eout);
        model_out = eout;
        @(posedge clk); #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_fault", fault, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
        vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
        vt[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
        vt[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_0080};
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 1'b0, 4'b1111, 32'h0, 32'h1234_5678};
        vt[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hAAAA_5555, 9, 1'b0, 4'b1111, 32'h0, 32'h1234_5678};
        vt[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 3, 1'b0, 4'b1100, 32'h0, 32'h0000_8001};
        vt[8]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_8001};
        vt[9]  = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_8001};
        vt[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_8001};
        vt[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_8001};
        vt[12] = '{1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h1234_565A, 32'h0, 2, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0000_8001};
        vt[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001};

        rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        exeOut = 32'h0; rd2 = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memout", memOut, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_be", bus.mem_be, 4'b0000);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;

        foreach (vt[k])
            run_op(vt[k].rd, vt[k].wr, vt[k].f3, vt[k].addr, vt[k].rd2, vt[k].rdata,
                   vt[k].dly, 1'b0, vt[k].efault, vt[k].ebe, vt[k].ewd, vt[k].eout);

        // Random accesses against a reference built from sizes, offsets and shifts.
        for (int n = 0; n < 200; n++) begin
            logic rd, wr, legal, legal_f3;
            logic [2:0] f3;
            logic [31:0] addr, d2, rdata, ewd, eout;
            logic [3:0] ebe;
            logic [63:0] mask, v;
            int sel, bytes, off, dly;
            sel = $urandom_range(0, 9);
            rd = (sel == 0) || (sel >= 2 && sel <= 5);
            wr = (sel == 0) || (sel >= 6);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom; d2 = $urandom; rdata = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            dly = $urandom_range(0, 5);
            bytes = 1 << f3[1:0];
            off = int'(addr[1:0]);
            if (rd && !wr)
                legal_f3 = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            else if (wr && !rd)
                legal_f3 = (f3 == 0) || (f3 == 1) || (f3 == 2);
            else
                legal_f3 = 1'b0;
            legal = legal_f3 && (off % bytes == 0);
            ebe = 4'(((1 << bytes) - 1) << off);
            if (bytes == 1)      ewd = d2[7:0] * 32'h0101_0101;
            else if (bytes == 2) ewd = d2[15:0] * 32'h0001_0001;
            else                 ewd = d2;
            mask = (64'h1 << (8 * bytes)) - 64'h1;
            v = ({32'h0, rdata} >> (8 * off)) & mask;
            if (!f3[2] && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
            eout = (legal && rd && dly < TMO) ? v[31:0] : model_out;
            run_op(rd, wr, f3, addr, d2, rdata, dly, 1'b1, !legal, ebe, ewd, eout);
        end

        // Reset while a store is in flight; ack in the reset cycle and one cycle later must be dropped.
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b010; exeOut = 32'h0000_0440; rd2 = 32'hCAFE_F00D;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rstmid_req_before", bus.mem_req, 1'b1);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        chk("rstmid_req", bus.mem_req, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_be", bus.mem_be, 4'b0000);
        chk("rstmid_addr", bus.mem_addr, 32'h0);
        chk("rstmid_wdata", bus.mem_wdata, 32'h0);
        chk("rstmid_memout", memOut, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("lateack_busy", busy, 1'b0);
        chk("lateack_done", done, 1'b0);
        chk("lateack_req", bus.mem_req, 1'b0);
        model_out = 32'h0;

        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0BAD_CAFE, 1, 1'b0,
               1'b0, 4'b1111, 32'h0, 32'h0BAD_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
